// File: rtl/glitch_sequencer.sv
// Timing controller for the glitch clock mux: arm, wait for a trigger edge, delay,
// then emit a programmable train of glitch-enable windows separated by gaps.
module glitch_sequencer #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             clk_in1,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [NUM_W-1:0] cfg_count,
  input  logic             arm,
  input  logic             abort,
  input  logic             trigger,
  output logic             glitch_en,
  output logic             switch_en,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulses_fired
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DELAY,
    ST_PULSE,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t state, next_state;

  logic             trig_q;
  logic             trig_edge;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             pulse_last;
  logic             cfg_take;

  logic [CNT_W-1:0] delay_r;
  logic [CNT_W-1:0] width_r;
  logic [CNT_W-1:0] gap_r;
  logic [NUM_W-1:0] count_r;

  assign trig_edge = trigger && !trig_q;
  assign cfg_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign cfg_take  = cfg_valid && cfg_ready;

  // Every timed state restarts the shared counter on entry and leaves when it
  // reaches field-1, so the full 1..2^CNT_W-1 range works without saturation.
  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    pulse_last = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm) next_state = ST_ARMED;
      end
      ST_ARMED: begin
        if (trig_edge) begin
          cnt_clr    = 1'b1;
          next_state = (delay_r == '0) ? ST_PULSE : ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (cnt == delay_r - CNT_W'(1)) begin
          cnt_clr    = 1'b1;
          next_state = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (cnt == width_r - CNT_W'(1)) begin
          cnt_clr    = 1'b1;
          pulse_last = 1'b1;
          next_state = (pulses_fired + NUM_W'(1) == count_r) ? ST_DONE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt == gap_r - CNT_W'(1)) begin
          cnt_clr    = 1'b1;
          next_state = ST_PULSE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
    // Abort wins over everything but reset and must not count a window.
    if (abort) begin
      next_state = ST_IDLE;
      pulse_last = 1'b0;
    end
  end

  always_ff @(posedge clk_in1) begin
    if (rst) begin
      state        <= ST_IDLE;
      trig_q       <= 1'b0;
      cnt          <= '0;
      delay_r      <= '0;
      width_r      <= CNT_W'(1);
      gap_r        <= CNT_W'(1);
      count_r      <= NUM_W'(1);
      pulses_fired <= '0;
      glitch_en    <= 1'b0;
      switch_en    <= 1'b0;
      done         <= 1'b0;
    end else begin
      state  <= next_state;
      trig_q <= trigger;
      cnt    <= cnt_clr ? '0 : cnt + CNT_W'(1);

      if (cfg_take) begin
        delay_r <= cfg_delay;
        width_r <= (cfg_width == '0) ? CNT_W'(1) : cfg_width;
        gap_r   <= (cfg_gap == '0)   ? CNT_W'(1) : cfg_gap;
        count_r <= (cfg_count == '0) ? NUM_W'(1) : cfg_count;
      end

      if (state == ST_IDLE && arm && !abort) begin
        pulses_fired <= '0;
      end else if (pulse_last) begin
        pulses_fired <= pulses_fired + NUM_W'(1);
      end

      // Registered decode of the next state keeps the mux controls glitch-free.
      glitch_en <= (next_state == ST_PULSE);
      switch_en <= (next_state == ST_DELAY) || (next_state == ST_PULSE) ||
                   (next_state == ST_GAP);
      done      <= (next_state == ST_DONE);
    end
  end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: per-cycle traces after a trigger edge are
// compared against hand-computed bit masks (bit k = cycle T+k).
module tb_glitch_sequencer;

  logic        clk_in1 = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_delay;
  logic [15:0] cfg_width;
  logic [15:0] cfg_gap;
  logic [7:0]  cfg_count;
  logic        arm;
  logic        abort;
  logic        trigger;
  logic        glitch_en;
  logic        switch_en;
  logic        busy;
  logic        done;
  logic [7:0]  pulses_fired;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ge_tr;
  logic [31:0] se_tr;
  logic [31:0] dn_tr;

  always #5 clk_in1 = ~clk_in1;

  glitch_sequencer #(.CNT_W(16), .NUM_W(8)) dut (
    .clk_in1     (clk_in1),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_delay   (cfg_delay),
    .cfg_width   (cfg_width),
    .cfg_gap     (cfg_gap),
    .cfg_count   (cfg_count),
    .arm         (arm),
    .abort       (abort),
    .trigger     (trigger),
    .glitch_en   (glitch_en),
    .switch_en   (switch_en),
    .busy        (busy),
    .done        (done),
    .pulses_fired(pulses_fired)
  );

  task automatic tick();
    @(posedge clk_in1);
    #1;
  endtask

  task automatic load_cfg(input logic [15:0] d, input logic [15:0] w,
                          input logic [15:0] g, input logic [7:0] c, input logic with_arm);
    cfg_delay = d;
    cfg_width = w;
    cfg_gap   = g;
    cfg_count = c;
    cfg_valid = 1'b1;
    arm       = with_arm;
    tick();
    cfg_valid = 1'b0;
    arm       = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Raise trigger so the edge is seen at posedge T, then record cycles T+1..T+n.
  task automatic capture(input int n);
    ge_tr = '0;
    se_tr = '0;
    dn_tr = '0;
    trigger = 1'b1;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == 1) trigger = 1'b0;
      ge_tr[k] = glitch_en;
      se_tr[k] = switch_en;
      dn_tr[k] = done;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
    cfg_delay = '0; cfg_width = '0; cfg_gap = '0; cfg_count = '0;
    tick();
    tick();
    n_cmp++;
    if ({glitch_en, switch_en, busy, done, cfg_ready} !== 5'b00001) begin
      n_err++;
      $display("[TB] FAIL reset_flags: got %b want 00001", {glitch_en, switch_en, busy, done, cfg_ready});
    end
    n_cmp++;
    if (pulses_fired !== 8'd0) begin
      n_err++;
      $display("[TB] FAIL reset_pulses: got %0d want 0", pulses_fired);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    load_cfg(16'd3, 16'd2, 16'd4, 8'd1, 1'b0);
    do_arm();
    n_cmp++;
    if ({busy, cfg_ready} !== 2'b10) begin
      n_err++;
      $display("[TB] FAIL single_armed: got %b want 10", {busy, cfg_ready});
    end
    capture(10);
    n_cmp++;
    if (ge_tr !== 32'h30) begin n_err++; $display("[TB] FAIL single_glitch: got %h want 30", ge_tr); end
    n_cmp++;
    if (se_tr !== 32'h3E) begin n_err++; $display("[TB] FAIL single_switch: got %h want 3e", se_tr); end
    n_cmp++;
    if (dn_tr !== 32'h40) begin n_err++; $display("[TB] FAIL single_done: got %h want 40", dn_tr); end
    n_cmp++;
    if (pulses_fired !== 8'd1) begin n_err++; $display("[TB] FAIL single_pulses: got %0d want 1", pulses_fired); end
    n_cmp++;
    if ({busy, cfg_ready} !== 2'b01) begin n_err++; $display("[TB] FAIL single_idle: got %b want 01", {busy, cfg_ready}); end
  endtask

  task automatic test_train_cfg_with_arm();
    load_cfg(16'd0, 16'd1, 16'd2, 8'd3, 1'b1);
    tick();
    capture(12);
    n_cmp++;
    if (ge_tr !== 32'h92) begin n_err++; $display("[TB] FAIL train_glitch: got %h want 92", ge_tr); end
    n_cmp++;
    if (se_tr !== 32'hFE) begin n_err++; $display("[TB] FAIL train_switch: got %h want fe", se_tr); end
    n_cmp++;
    if (dn_tr !== 32'h100) begin n_err++; $display("[TB] FAIL train_done: got %h want 100", dn_tr); end
    n_cmp++;
    if (pulses_fired !== 8'd3) begin n_err++; $display("[TB] FAIL train_pulses: got %0d want 3", pulses_fired); end
  endtask

  task automatic test_zero_fields();
    load_cfg(16'd2, 16'd0, 16'd0, 8'd0, 1'b0);
    do_arm();
    capture(8);
    n_cmp++;
    if (ge_tr !== 32'h8) begin n_err++; $display("[TB] FAIL zero_glitch: got %h want 8", ge_tr); end
    n_cmp++;
    if (se_tr !== 32'hE) begin n_err++; $display("[TB] FAIL zero_switch: got %h want e", se_tr); end
    n_cmp++;
    if (dn_tr !== 32'h10) begin n_err++; $display("[TB] FAIL zero_done: got %h want 10", dn_tr); end
    n_cmp++;
    if (pulses_fired !== 8'd1) begin n_err++; $display("[TB] FAIL zero_pulses: got %0d want 1", pulses_fired); end
  endtask

  task automatic test_trigger_held();
    logic any_out;
    load_cfg(16'd1, 16'd1, 16'd1, 8'd1, 1'b0);
    trigger = 1'b1;
    tick();
    tick();
    do_arm();
    any_out = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      any_out = any_out | glitch_en | switch_en | done;
    end
    n_cmp++;
    if ({any_out, busy} !== 2'b01) begin
      n_err++;
      $display("[TB] FAIL held_no_start: got %b want 01", {any_out, busy});
    end
    trigger = 1'b0;
    tick();
    capture(6);
    n_cmp++;
    if (ge_tr !== 32'h4) begin n_err++; $display("[TB] FAIL held_glitch: got %h want 4", ge_tr); end
    n_cmp++;
    if (dn_tr !== 32'h8) begin n_err++; $display("[TB] FAIL held_done: got %h want 8", dn_tr); end
  endtask

  task automatic test_abort();
    logic saw_done;
    load_cfg(16'd0, 16'd5, 16'd1, 8'd2, 1'b0);
    do_arm();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    n_cmp++;
    if (glitch_en !== 1'b1) begin n_err++; $display("[TB] FAIL abort_pre_glitch: got %b want 1", glitch_en); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if ({glitch_en, switch_en, busy, done, cfg_ready} !== 5'b00001) begin
      n_err++;
      $display("[TB] FAIL abort_outputs: got %b want 00001", {glitch_en, switch_en, busy, done, cfg_ready});
    end
    saw_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      saw_done = saw_done | done | busy;
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin n_err++; $display("[TB] FAIL abort_no_done: got %b want 0", saw_done); end
    n_cmp++;
    if (pulses_fired !== 8'd0) begin n_err++; $display("[TB] FAIL abort_pulses: got %0d want 0", pulses_fired); end
  endtask

  task automatic test_ignored_inputs();
    logic ready_mid;
    load_cfg(16'd4, 16'd2, 16'd1, 8'd2, 1'b0);
    do_arm();
    ge_tr = '0; se_tr = '0; dn_tr = '0;
    ready_mid = 1'b1;
    trigger = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      ge_tr[k] = glitch_en;
      se_tr[k] = switch_en;
      dn_tr[k] = done;
      case (k)
        1: begin
          ready_mid = cfg_ready;
          cfg_delay = 16'd9; cfg_width = 16'd7; cfg_gap = 16'd7; cfg_count = 8'd5;
          cfg_valid = 1'b1;
          arm       = 1'b1;
        end
        2: begin cfg_valid = 1'b0; arm = 1'b0; trigger = 1'b0; end
        5: trigger = 1'b1;
        7: trigger = 1'b0;
        default: ;
      endcase
    end
    n_cmp++;
    if (ready_mid !== 1'b0) begin n_err++; $display("[TB] FAIL busy_cfg_ready: got %b want 0", ready_mid); end
    n_cmp++;
    if (ge_tr !== 32'h360) begin n_err++; $display("[TB] FAIL busy_glitch: got %h want 360", ge_tr); end
    n_cmp++;
    if (se_tr !== 32'h3FE) begin n_err++; $display("[TB] FAIL busy_switch: got %h want 3fe", se_tr); end
    n_cmp++;
    if (dn_tr !== 32'h400) begin n_err++; $display("[TB] FAIL busy_done: got %h want 400", dn_tr); end
    n_cmp++;
    if (pulses_fired !== 8'd2) begin n_err++; $display("[TB] FAIL busy_pulses: got %0d want 2", pulses_fired); end
    do_arm();
    capture(14);
    n_cmp++;
    if (ge_tr !== 32'h360) begin n_err++; $display("[TB] FAIL cfg_unchanged: got %h want 360", ge_tr); end
  endtask

  task automatic test_reset_mid_pulse();
    load_cfg(16'd0, 16'd3, 16'd3, 8'd2, 1'b0);
    do_arm();
    trigger = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      trigger = 1'b0;
    end
    n_cmp++;
    if ({glitch_en, pulses_fired} !== {1'b1, 8'd1}) begin
      n_err++;
      $display("[TB] FAIL rst_pre_state: got %b/%0d want 1/1", glitch_en, pulses_fired);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({glitch_en, switch_en, busy, done, cfg_ready} !== 5'b00001) begin
      n_err++;
      $display("[TB] FAIL rst_outputs: got %b want 00001", {glitch_en, switch_en, busy, done, cfg_ready});
    end
    n_cmp++;
    if (pulses_fired !== 8'd0) begin n_err++; $display("[TB] FAIL rst_pulses: got %0d want 0", pulses_fired); end
    tick();
    do_arm();
    capture(6);
    n_cmp++;
    if (ge_tr !== 32'h2) begin n_err++; $display("[TB] FAIL rst_cfg_glitch: got %h want 2", ge_tr); end
    n_cmp++;
    if (dn_tr !== 32'h4) begin n_err++; $display("[TB] FAIL rst_cfg_done: got %h want 4", dn_tr); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_train_cfg_with_arm();
    test_zero_fields();
    test_trigger_held();
    test_abort();
    test_ignored_inputs();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
- Timing controller for the glitch clock mux.
- After being armed, it waits for a trigger rising edge, then a programmable delay. It then emits a programmable number of glitch-enable windows of programmable width, separated by a programmable gap.
- glitch_en drives the mux `cnt` select input; switch_en drives the mux `switch` input.
- Configuration arrives as a single-beat write from the UART command decoder.

Parameters:
- CNT_W, 16, width of the delay, width and gap counters.
- NUM_W, 8, width of the pulse-count field.

Ports:
- clk_in1  in  1  system clock; the same clock fed to the mux.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config write strobe. Accepted only when cfg_valid && cfg_ready.
- cfg_ready  out  1  high only in IDLE.
- cfg_delay  in  CNT_W  cycles from trigger detection to the first pulse.
- cfg_width  in  CNT_W  cycles per glitch window (0 treated as 1).
- cfg_gap  in  CNT_W  cycles between windows (0 treated as 1).
- cfg_count  in  NUM_W  number of windows (0 treated as 1).
- arm  in  1  single-cycle request to leave IDLE.
- abort  in  1  forces return to IDLE from any state.
- trigger  in  1  target event, already synchronous to clk_in1.
- glitch_en  out  1  registered; high during each glitch window.
- switch_en  out  1  registered; high from trigger detection through end of the last window.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the sequence completes normally.
- pulses_fired  out  NUM_W  windows completed in the current or last run.

Behaviour:
- Reset values: glitch_en=0, switch_en=0, busy=0, done=0, cfg_ready=1, pulses_fired=0, state=IDLE, trig_q=0. Config registers reset to delay=0, width=1, gap=1, count=1.
- Edge detect: trig_q is a registered copy of trigger. An edge is trigger && !trig_q, and is only acted on in ARMED.
- States: IDLE, ARMED, DELAY, PULSE, GAP, DONE.
- IDLE:
  - A cfg handshake latches all four fields, with 0→1 substitution for width, gap and count.
  - arm → ARMED and clears pulses_fired.
  - If cfg_valid and arm arrive together, both take effect; ARMED uses the new config.
- ARMED: waits for an edge. A trigger already high when ARMED is entered is not an edge; it must fall and rise again.
- Edge detected at posedge T:
  - If delay>0, go to DELAY with counter=0.
  - If delay==0, go straight to PULSE.
  - switch_en=1 from cycle T+1.
- DELAY: counts delay cycles, then enters PULSE. glitch_en rises in cycle T+1+delay.
- PULSE:
  - glitch_en=1 for exactly width cycles.
  - On the last cycle, pulses_fired increments.
  - If pulses_fired+1 == count, go to DONE; otherwise go to GAP.
- GAP: glitch_en=0 for exactly gap cycles, then PULSE.
- DONE: one cycle with done=1, glitch_en=0, switch_en=0, busy=1, then IDLE.
- Outputs are a registered decode of the next state, so glitch_en and switch_en are glitch-free.
- Abort:
  - Highest priority in any state: on the next cycle the block is in IDLE with glitch_en=0 and switch_en=0.
  - done is not pulsed; pulses_fired is held.
  - Reset has priority over abort.
- Config: cfg_valid while busy is ignored; cfg_ready=0 and the registers are unchanged.
- Counters:
  - Saturation cannot occur: comparisons use cnt == field-1 with CNT_W-bit wrap.
  - The full range 1..2^CNT_W-1 is supported.
- Ignored inputs:
  - arm outside IDLE.
  - trigger edges outside ARMED, including edges arriving during a sequence.

Test Plan:
- Reset, then cfg delay=3, width=2, gap=4, count=1; arm; trigger rises at posedge T:
  - glitch_en is high in cycles T+4 and T+5 only.
  - done pulses at T+6.
  - switch_en is high T+1..T+5.
  - pulses_fired=1.
- cfg delay=0, width=1, gap=2, count=3:
  - glitch_en is high at T+1, T+4 and T+7.
  - done pulses at T+8.
  - pulses_fired=3.
- cfg width=0, gap=0, count=0: behaves as width=1, gap=1, count=1, giving exactly one 1-cycle window.
- Hold trigger high before arm, then arm:
  - No sequence starts.
  - Drop trigger, then raise it at T: sequence starts with first glitch_en at T+1+delay.
- abort asserted in the second PULSE cycle of width=5, count=2:
  - Next cycle: IDLE, glitch_en=0, switch_en=0, busy=0.
  - No done pulse; pulses_fired=0.
- cfg_valid with delay=9 during DELAY is ignored (cfg_ready=0). A second trigger edge mid-sequence is ignored. Sync rst mid-PULSE returns all outputs to their reset values on the next edge.
